// File: rtl/sdram_arb_pkg.sv
// Shared types and helpers for the SDRAM Wishbone arbiter and other
// multi-master blocks: FSM state encoding and a round-robin pick function.
package sdram_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } arb_state_t;

  // The picker is written for the widest supported configuration; narrower
  // users zero-extend their request vector and index into these widths.
  localparam int MAX_PORTS = 8;
  localparam int MAX_IDX_W = 3;
  localparam int NUM_W     = MAX_IDX_W + 1;

  // First requesting index strictly after 'last', scanning upward modulo
  // 'num'. Returns 'last' unchanged when nothing requests.
  function automatic logic [MAX_IDX_W-1:0] rr_next(
    input logic [MAX_PORTS-1:0] req,
    input logic [MAX_IDX_W-1:0] last,
    input logic [NUM_W-1:0]     num
  );
    logic [MAX_IDX_W-1:0] pick;
    logic                 found;
    logic [NUM_W-1:0]     cand;
    pick  = last;
    found = 1'b0;
    for (int k = 1; k <= MAX_PORTS; k++) begin
      // last < num and k <= num, so one subtraction wraps the candidate
      cand = {1'b0, last} + k[NUM_W-1:0];
      if (cand >= num) begin
        cand = cand - num;
      end else begin
        cand = cand;
      end
      if (!found && (k <= int'(num)) && req[cand[MAX_IDX_W-1:0]]) begin
        pick  = cand[MAX_IDX_W-1:0];
        found = 1'b1;
      end else begin
        found = found;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/sdram_wishbone_arbiter_rr_arbiter.sv
// Combinational round-robin picker: given a request vector and the last
// granted index, returns the next index to serve and whether any port asks.
module rr_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int  NUM_PORTS = 4,
  localparam int IDX_W     = $clog2(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [IDX_W-1:0]     last,
  output logic [IDX_W-1:0]     idx,
  output logic                 valid
);

  logic [MAX_PORTS-1:0] req_ext_s;
  logic [MAX_IDX_W-1:0] last_ext_s;
  logic [MAX_IDX_W-1:0] pick_s;

  assign req_ext_s  = MAX_PORTS'(req);
  assign last_ext_s = MAX_IDX_W'(last);
  assign pick_s     = rr_next(req_ext_s, last_ext_s, NUM_W'(NUM_PORTS));
  assign idx        = IDX_W'(pick_s);
  assign valid      = |req;

endmodule

// File: rtl/sdram_wishbone_arbiter.sv
// N-port classic Wishbone arbiter in front of the SDRAM controller user port.
// One access in flight, round-robin grant, grants held off until the
// controller finishes init, and a timeout that answers err instead of hanging.
module sdram_wishbone_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int  NUM_PORTS = 4,
  parameter int  ADDR_W    = 24,
  parameter int  DATA_W    = 16,
  parameter int  TIMEOUT   = 1024,
  localparam int SEL_W     = DATA_W / 8,
  localparam int IDX_W     = $clog2(NUM_PORTS)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        init_done,
  input  logic [NUM_PORTS*ADDR_W-1:0] m_adr,
  input  logic [NUM_PORTS*DATA_W-1:0] m_dat_w,
  input  logic [NUM_PORTS*SEL_W-1:0]  m_sel,
  input  logic [NUM_PORTS-1:0]        m_we,
  input  logic [NUM_PORTS-1:0]        m_cyc,
  input  logic [NUM_PORTS-1:0]        m_stb,
  output logic [DATA_W-1:0]           m_dat_r,
  output logic [NUM_PORTS-1:0]        m_ack,
  output logic [NUM_PORTS-1:0]        m_err,
  output logic [ADDR_W-1:0]           s_adr,
  output logic [DATA_W-1:0]           s_dat_w,
  output logic [SEL_W-1:0]            s_sel,
  output logic                        s_we,
  output logic                        s_cyc,
  output logic                        s_stb,
  input  logic [DATA_W-1:0]           s_dat_r,
  input  logic                        s_ack,
  input  logic                        s_err,
  output logic [IDX_W-1:0]            grant,
  output logic                        timeout_err
);

  localparam int               CNT_W      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1'b1);
  localparam logic             TIMEOUT_EN = (TIMEOUT > 0);

  arb_state_t           state_r;
  logic [CNT_W-1:0]     cnt_r;
  logic [NUM_PORTS-1:0] req_s;
  logic [IDX_W-1:0]     pick_s;
  logic                 pick_valid_s;
  logic [ADDR_W-1:0]    pick_adr_s;
  logic [DATA_W-1:0]    pick_dat_s;
  logic [SEL_W-1:0]     pick_sel_s;
  logic                 pick_we_s;
  logic                 grant_cyc_s;
  logic [NUM_PORTS-1:0] grant_onehot_s;
  logic                 timeout_hit_s;

  assign req_s          = m_cyc & m_stb;
  assign grant_onehot_s = {{(NUM_PORTS-1){1'b0}}, 1'b1} << grant;
  assign timeout_hit_s  = TIMEOUT_EN && (cnt_r == CNT_LAST);

  rr_arbiter #(
    .NUM_PORTS(NUM_PORTS)
  ) u_rr (
    .req  (req_s),
    .last (grant),
    .idx  (pick_s),
    .valid(pick_valid_s)
  );

  // AND-OR mux of the picked port's request fields and the granted port's cyc
  always_comb begin
    pick_adr_s  = '0;
    pick_dat_s  = '0;
    pick_sel_s  = '0;
    pick_we_s   = 1'b0;
    grant_cyc_s = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      pick_adr_s  = pick_adr_s | ({ADDR_W{pick_s == IDX_W'(i)}} & m_adr[i*ADDR_W +: ADDR_W]);
      pick_dat_s  = pick_dat_s | ({DATA_W{pick_s == IDX_W'(i)}} & m_dat_w[i*DATA_W +: DATA_W]);
      pick_sel_s  = pick_sel_s | ({SEL_W{pick_s == IDX_W'(i)}} & m_sel[i*SEL_W +: SEL_W]);
      pick_we_s   = pick_we_s | ((pick_s == IDX_W'(i)) & m_we[i]);
      grant_cyc_s = grant_cyc_s | ((grant == IDX_W'(i)) & m_cyc[i]);
    end
  end

  // Arbitration FSM driving registered downstream signals and response pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      cnt_r       <= '0;
      grant       <= IDX_W'(NUM_PORTS - 1);
      s_adr       <= '0;
      s_dat_w     <= '0;
      s_sel       <= '0;
      s_we        <= 1'b0;
      s_cyc       <= 1'b0;
      s_stb       <= 1'b0;
      m_dat_r     <= '0;
      m_ack       <= '0;
      m_err       <= '0;
      timeout_err <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          m_ack       <= '0;
          m_err       <= '0;
          timeout_err <= 1'b0;
          if (init_done && pick_valid_s) begin
            grant   <= pick_s;
            s_adr   <= pick_adr_s;
            s_dat_w <= pick_dat_s;
            s_sel   <= pick_sel_s;
            s_we    <= pick_we_s;
            s_cyc   <= 1'b1;
            s_stb   <= 1'b1;
            cnt_r   <= '0;
            state_r <= ST_BUSY;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_BUSY: begin
          if (s_err || s_ack) begin
            // err wins when both arrive together
            m_dat_r <= s_dat_r;
            if (s_err) begin
              m_err <= grant_onehot_s;
            end else begin
              m_ack <= grant_onehot_s;
            end
            s_cyc   <= 1'b0;
            s_stb   <= 1'b0;
            state_r <= ST_DONE;
          end else if (!grant_cyc_s) begin
            // master abandoned the access: no response is owed
            s_cyc   <= 1'b0;
            s_stb   <= 1'b0;
            state_r <= ST_DONE;
          end else if (timeout_hit_s) begin
            m_err       <= grant_onehot_s;
            timeout_err <= 1'b1;
            s_cyc       <= 1'b0;
            s_stb       <= 1'b0;
            state_r     <= ST_DONE;
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        ST_DONE: begin
          // one quiet cycle lets the master drop stb before re-arbitration
          m_ack       <= '0;
          m_err       <= '0;
          timeout_err <= 1'b0;
          state_r     <= ST_IDLE;
        end
        default: begin
          s_cyc       <= 1'b0;
          s_stb       <= 1'b0;
          m_ack       <= '0;
          m_err       <= '0;
          timeout_err <= 1'b0;
          state_r     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/sdram_wishbone_arbiter.md
# sdram_wishbone_arbiter

N-port Wishbone (classic, non-pipelined) arbiter that shares the single user Wishbone port of the SDRAM controller among several masters in the system clock domain. Round-robin grant, one transaction in flight, request gating until SDRAM init completes, and a per-transaction timeout that returns `err` instead of hanging a master. Sits between user logic and the controller's `user_port_wishbone_0_*` port.

## Interface
Parameters:
- `NUM_PORTS`, 4: number of upstream masters (2..8).
- `ADDR_W`, 24: word address width.
- `DATA_W`, 16: data width; multiple of 8.
- `SEL_W`, DATA_W/8: byte-select width (derived; not overridable).
- `TIMEOUT`, 1024: cycles in BUSY before forced error; 0 disables the timeout.

Ports:
- `clk`  in  1  system clock; every register is clocked on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `init_done`  in  1  SDRAM controller init complete.
- `m_adr`  in  NUM_PORTS*ADDR_W  per-port address, port i at bits [i*ADDR_W +: ADDR_W].
- `m_dat_w`  in  NUM_PORTS*DATA_W  per-port write data.
- `m_sel`  in  NUM_PORTS*SEL_W  per-port byte selects.
- `m_we`, `m_cyc`, `m_stb`  in  NUM_PORTS  per-port control.
- `m_dat_r`  out  DATA_W  read data, shared by all ports; valid while the port's ack is high.
- `m_ack`, `m_err`  out  NUM_PORTS  per-port one-cycle response pulses.
- `s_adr`  out  ADDR_W; `s_dat_w`  out  DATA_W; `s_sel`  out  SEL_W; `s_we`, `s_cyc`, `s_stb`  out  1  downstream master signals, all registered.
- `s_dat_r`  in  DATA_W; `s_ack`, `s_err`  in  1  downstream response.
- `grant`  out  $clog2(NUM_PORTS)  index of the current or last granted port.
- `timeout_err`  out  1  one-cycle pulse when a timeout fires.

## Operation
- A port requests when `m_cyc[i] & m_stb[i]`.
- FSM states: IDLE, BUSY, DONE.
- IDLE: if `init_done` and any request is present, choose the first requesting port after `grant`, scanning upward modulo NUM_PORTS. Latch that port's adr/dat_w/sel/we into `s_*`, set `s_cyc=s_stb=1`, update `grant`, clear the timeout counter, and go to BUSY. With no request, or with `init_done=0`, stay in IDLE.
- BUSY:
  - `s_ack`: latch `s_dat_r` into `m_dat_r`, set `m_ack[grant]=1`, drop `s_cyc`/`s_stb`, go to DONE.
  - `s_err`: same, but pulse `m_err[grant]` instead of `m_ack`.
  - If `s_ack` and `s_err` are both high, err wins.
  - Granted master drops `m_cyc` (abort): drop `s_cyc`/`s_stb`, send no response, go to DONE.
  - Counter reaches TIMEOUT-1 with no response: pulse `m_err[grant]` and `timeout_err`, drop `s_cyc`/`s_stb`, go to DONE.
  - Response takes priority over abort, and abort over timeout, when they coincide in the same cycle.
- DONE: lasts exactly one cycle. Clear all response pulses and go to IDLE. Any `s_ack`/`s_err` seen in DONE or IDLE is ignored, so a late ack after a timeout is dropped. DONE exists so the master can deassert `stb` before re-arbitration and is not granted twice for one access.
- `init_done` falling during BUSY does not abort the transaction; it only blocks new grants.

## Timing
- Reset values: state IDLE; `s_cyc`, `s_stb`, `s_we`, `m_ack`, `m_err`, `timeout_err` = 0; `s_adr`, `s_dat_w`, `s_sel`, `m_dat_r` = 0; `grant` = NUM_PORTS-1, so port 0 wins first.
- Reset asserted mid-transaction forces these values immediately (async). The downstream cycle is simply abandoned.
- Request sampled at edge E: `s_cyc`/`s_stb` are high after E.
- `s_ack` sampled at edge F: `m_ack` is high for the cycle after F, and `s_cyc` is low in the same cycle.
- Minimum occupancy is 3 cycles per access: IDLE, BUSY (zero-wait downstream), DONE.
- A timeout fires when BUSY has lasted TIMEOUT cycles; the err pulse is visible in the following cycle.
- Fairness: a port that is continuously requesting waits at most NUM_PORTS-1 transactions.

## Structure
- Shared package `sdram_arb_pkg`:
  - state enum `arb_state_t` (IDLE, BUSY, DONE);
  - function `rr_next(req, last)` returning the next grant index.
- One natural sub-module, `rr_arbiter`: a combinational round-robin picker (req vector plus last index gives index and valid), reusable by other multi-master blocks.
- The FSM, timeout counter and `s_*` registers live in the top module.

## Test plan
- Single read, port 2, adr 0x000123, downstream acks after 3 cycles with 0xBEEF -> `s_adr`=0x000123 the cycle after the request; `m_ack[2]` pulses once with `m_dat_r`=0xBEEF; `s_cyc` is low in the ack cycle.
- All 4 ports request continuously, zero-wait slave -> grants run 0,1,2,3,0; each access takes exactly 3 cycles.
- `init_done`=0 with port 1 requesting for 20 cycles -> `s_cyc` stays 0. Raise `init_done` -> `s_cyc` rises on the next edge with port 1's address.
- TIMEOUT=16, slave never acks -> `m_err[0]` and `timeout_err` pulse exactly 16 cycles after `s_cyc` rises. A late `s_ack` two cycles later produces no `m_ack`.
- Port 3 drops `m_cyc` during BUSY -> `s_cyc` low on the next edge, no `m_ack[3]` or `m_err[3]`, and the next requester is granted after DONE.
- `rst_n` pulsed low mid-BUSY, asynchronous to `clk` -> all outputs are at reset values before the next edge; the first grant after release goes to port 0.
